// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI4 read-channel arbiter: S_COUNT requesters share one master read port.
// An order FIFO of granted port indices steers each returning R burst back to its issuer.
module axi_rd_arbiter #(
    parameter int S_COUNT         = 2,
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*ID_WIDTH-1:0]   s_axi_arid,
    input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [S_COUNT*8-1:0]          s_axi_arlen,
    input  logic [S_COUNT*3-1:0]          s_axi_arsize,
    input  logic [S_COUNT*2-1:0]          s_axi_arburst,
    input  logic [S_COUNT-1:0]            s_axi_arvalid,
    output logic [S_COUNT-1:0]            s_axi_arready,
    output logic [ID_WIDTH-1:0]           s_axi_rid,
    output logic [DATA_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic [S_COUNT-1:0]            s_axi_rvalid,
    input  logic [S_COUNT-1:0]            s_axi_rready,
    output logic [ID_WIDTH-1:0]           m_axi_arid,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [ID_WIDTH-1:0]           m_axi_rid,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);
    localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [0:0] {AR_IDLE = 1'b0, AR_HOLD = 1'b1} ar_state_t;

    ar_state_t        ar_state_r;
    logic [IDX_W-1:0] last_grant_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic [IDX_W-1:0] order_mem_r [MAX_OUTSTANDING];

    logic [IDX_W-1:0] grant_idx_s;
    logic [IDX_W-1:0] head_s;
    logic             grant_found_s;
    logic             grant_s;
    logic             order_empty_s;
    logic             order_full_s;
    logic             pop_s;

    logic [ID_WIDTH-1:0]   arid_s    [S_COUNT];
    logic [ADDR_WIDTH-1:0] araddr_s  [S_COUNT];
    logic [7:0]            arlen_s   [S_COUNT];
    logic [2:0]            arsize_s  [S_COUNT];
    logic [1:0]            arburst_s [S_COUNT];

    for (genvar k = 0; k < S_COUNT; k++) begin : g_port
        assign arid_s[k]        = s_axi_arid[k*ID_WIDTH +: ID_WIDTH];
        assign araddr_s[k]      = s_axi_araddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign arlen_s[k]       = s_axi_arlen[k*8 +: 8];
        assign arsize_s[k]      = s_axi_arsize[k*3 +: 3];
        assign arburst_s[k]     = s_axi_arburst[k*2 +: 2];
        assign s_axi_arready[k] = grant_s && (grant_idx_s == IDX_W'(k));
        assign s_axi_rvalid[k]  = m_axi_rvalid && !order_empty_s && (head_s == IDX_W'(k));
    end

    // Round-robin search beginning at the port after the last grant and wrapping
    always_comb begin
        logic [IDX_W:0] sum_v;
        logic [IDX_W:0] cand_v;
        logic           hit_v;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        sum_v         = '0;
        cand_v        = '0;
        hit_v         = 1'b0;
        for (int i = 1; i <= S_COUNT; i++) begin
            sum_v         = {1'b0, last_grant_r} + (IDX_W+1)'(i);
            cand_v        = (sum_v >= (IDX_W+1)'(S_COUNT)) ? (sum_v - (IDX_W+1)'(S_COUNT)) : sum_v;
            hit_v         = !grant_found_s && s_axi_arvalid[cand_v[IDX_W-1:0]];
            grant_idx_s   = hit_v ? cand_v[IDX_W-1:0] : grant_idx_s;
            grant_found_s = grant_found_s || hit_v;
        end
    end

    assign order_empty_s = (wr_ptr_r == rd_ptr_r);
    assign order_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                           (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign head_s        = order_mem_r[rd_ptr_r[PTR_W-1:0]];

    // rst_n gates the grant so arready stays low while the block is held in reset
    assign grant_s = rst_n && (ar_state_r == AR_IDLE) && grant_found_s &&
                     (outstanding_r < CNT_W'(MAX_OUTSTANDING)) && !order_full_s;

    assign m_axi_rready = !order_empty_s && s_axi_rready[head_s];
    assign pop_s        = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;

    // AR FSM: latch the granted request, then hold it until the master accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_state_r    <= AR_IDLE;
            last_grant_r  <= IDX_W'(S_COUNT - 1);
            m_axi_arid    <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= 8'd0;
            m_axi_arsize  <= 3'd0;
            m_axi_arburst <= 2'd0;
            m_axi_arvalid <= 1'b0;
        end else begin
            case (ar_state_r)
                AR_IDLE: begin
                    if (grant_s) begin
                        m_axi_arid    <= arid_s[grant_idx_s];
                        m_axi_araddr  <= araddr_s[grant_idx_s];
                        m_axi_arlen   <= arlen_s[grant_idx_s];
                        m_axi_arsize  <= arsize_s[grant_idx_s];
                        m_axi_arburst <= arburst_s[grant_idx_s];
                        m_axi_arvalid <= 1'b1;
                        last_grant_r  <= grant_idx_s;
                        ar_state_r    <= AR_HOLD;
                    end else begin
                        ar_state_r    <= AR_IDLE;
                    end
                end
                AR_HOLD: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        ar_state_r    <= AR_IDLE;
                    end else begin
                        ar_state_r    <= AR_HOLD;
                    end
                end
                default: begin
                    m_axi_arvalid <= 1'b0;
                    ar_state_r    <= AR_IDLE;
                end
            endcase
        end
    end

    // Order FIFO pointers and outstanding-burst counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            outstanding_r <= '0;
        end else begin
            wr_ptr_r <= grant_s ? (wr_ptr_r + (PTR_W+1)'(1)) : wr_ptr_r;
            rd_ptr_r <= pop_s ? (rd_ptr_r + (PTR_W+1)'(1)) : rd_ptr_r;
            case ({grant_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Order FIFO storage; contents are qualified by the pointers
    always_ff @(posedge clk) begin
        if (grant_s) begin
            order_mem_r[wr_ptr_r[PTR_W-1:0]] <= grant_idx_s;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter: a queue-based grant/order model predicts
// AR grants and R routing; expected AR and R transactions are queued and popped by monitors.
module tb_axi_rd_arbiter;
    localparam int S  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [S*IW-1:0] s_axi_arid = '0;
    logic [S*AW-1:0] s_axi_araddr = '0;
    logic [S*8-1:0]  s_axi_arlen = '0;
    logic [S*3-1:0]  s_axi_arsize = '0;
    logic [S*2-1:0]  s_axi_arburst = '0;
    logic [S-1:0]    s_axi_arvalid = '0;
    logic [S-1:0]    s_axi_arready;
    logic [IW-1:0]   s_axi_rid;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast;
    logic [S-1:0]    s_axi_rvalid;
    logic [S-1:0]    s_axi_rready = '0;
    logic [IW-1:0]   m_axi_arid;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_axi_arvalid;
    logic            m_axi_arready = 1'b0;
    logic [IW-1:0]   m_axi_rid = '0;
    logic [DW-1:0]   m_axi_rdata = '0;
    logic [1:0]      m_axi_rresp = '0;
    logic            m_axi_rlast = 1'b0;
    logic            m_axi_rvalid = 1'b0;
    logic            m_axi_rready;

    axi_rd_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                     .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len;
        logic [2:0] size; logic [1:0] burst; int port;
    } ar_t;
    typedef struct { int port; logic [7:0] len; logic [IW-1:0] id; } burst_t;
    typedef struct {
        int port; logic [DW-1:0] data; logic [1:0] resp; logic [IW-1:0] id; logic last;
    } beat_t;

    // reference model: grant order queue, last grant, AR pending on master
    int     m_oq[$];
    int     m_last = S - 1;
    bit     m_hold = 1'b0;
    ar_t    ar_exp_q[$];
    burst_t sl_q[$];
    beat_t  r_exp_q[$];

    logic [AW-1:0] req_addr[S];
    logic [7:0]    req_len[S];
    logic [IW-1:0] req_id[S];
    logic [2:0]    req_size[S];
    logic [1:0]    req_burst[S];
    bit            req_active[S];
    bit            ar_taken[S];
    bit            r_taken = 1'b0;
    bit            beat_pending = 1'b0;
    int            beat_idx = 0;

    int req_pct = 0, arready_pct = 100, rready_pct = 100, rvalid_pct = 100;
    bit slave_en = 1'b0, bogus = 1'b0, count_grants = 1'b0;
    int grant_cnt = 0;
    int n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit vbit(input logic [S-1:0] v, input int i);
        logic [S-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        m_oq.delete(); ar_exp_q.delete(); r_exp_q.delete(); sl_q.delete();
        m_hold = 1'b0;
        m_last = S - 1;
    endtask

    // drivers: requesters, master arready, slave R beats, requester rready
    initial begin : drivers
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                for (int k = 0; k < S; k++) req_active[k] = 1'b0;
                s_axi_arvalid = '0; s_axi_rready = '0; m_axi_arready = 1'b0;
                m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                beat_pending = 1'b0; beat_idx = 0; sl_q.delete();
            end else begin
                for (int k = 0; k < S; k++) begin
                    if (ar_taken[k]) req_active[k] = 1'b0;
                    if (!req_active[k] && int'($urandom_range(99, 0)) < req_pct) begin
                        req_active[k] = 1'b1;
                        req_addr[k]   = AW'($urandom);
                        req_len[k]    = 8'($urandom_range(3, 0));
                        req_id[k]     = IW'($urandom);
                        req_size[k]   = 3'($urandom);
                        req_burst[k]  = 2'($urandom);
                    end
                    s_axi_arvalid[k]          = req_active[k];
                    s_axi_araddr[k*AW +: AW]  = req_addr[k];
                    s_axi_arlen[k*8 +: 8]     = req_len[k];
                    s_axi_arid[k*IW +: IW]    = req_id[k];
                    s_axi_arsize[k*3 +: 3]    = req_size[k];
                    s_axi_arburst[k*2 +: 2]   = req_burst[k];
                    s_axi_rready[k] = (int'($urandom_range(99, 0)) < rready_pct);
                end
                m_axi_arready = (int'($urandom_range(99, 0)) < arready_pct);
                if (r_taken && beat_pending) begin
                    beat_pending = 1'b0;
                    if (m_axi_rlast) begin
                        void'(sl_q.pop_front());
                        beat_idx = 0;
                    end else begin
                        beat_idx++;
                    end
                end
                if (!beat_pending && slave_en && sl_q.size() > 0 &&
                    int'($urandom_range(99, 0)) < rvalid_pct) begin
                    beat_pending = 1'b1;
                    m_axi_rdata  = DW'($urandom);
                    m_axi_rresp  = 2'($urandom);
                    m_axi_rid    = sl_q[0].id;
                    m_axi_rlast  = (beat_idx == int'(sl_q[0].len));
                    r_exp_q.push_back('{sl_q[0].port, m_axi_rdata, m_axi_rresp, m_axi_rid, m_axi_rlast});
                end
                if (bogus && !beat_pending) m_axi_rlast = 1'b1;
                m_axi_rvalid = beat_pending || bogus;
            end
        end
    end

    // model + monitors, evaluated mid-cycle while all signals are stable
    initial begin : monitor
        int eg, head, p;
        logic [S-1:0] er, erv;
        logic emr;
        ar_t a;
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int k = 0; k < S; k++) ar_taken[k] = 1'b0;
                r_taken = 1'b0;
            end else begin
                eg = -1;
                if (!m_hold && m_oq.size() < MO) begin
                    for (int i = 1; i <= S; i++) begin
                        p = (m_last + i) % S;
                        if (eg < 0 && vbit(s_axi_arvalid, p)) eg = p;
                    end
                end
                er = (eg >= 0) ? (S'(1) << eg) : '0;
                check("s_arready", 64'(s_axi_arready), 64'(er));
                check("m_arvalid", 64'(m_axi_arvalid), 64'(m_hold));
                head = (m_oq.size() > 0) ? m_oq[0] : -1;
                erv  = (head >= 0 && m_axi_rvalid) ? (S'(1) << head) : '0;
                emr  = (head >= 0) ? vbit(s_axi_rready, head) : 1'b0;
                check("s_rvalid", 64'(s_axi_rvalid), 64'(erv));
                check("m_rready", 64'(m_axi_rready), 64'(emr));
                if (count_grants && s_axi_arready != '0) grant_cnt++;
                if (m_hold && m_axi_arready) begin
                    if (ar_exp_q.size() == 0) begin
                        check("ar_unexpected", 64'd1, 64'd0);
                    end else begin
                        a = ar_exp_q.pop_front();
                        check("m_araddr", 64'(m_axi_araddr), 64'(a.addr));
                        check("m_arid", 64'(m_axi_arid), 64'(a.id));
                        check("m_arlen", 64'(m_axi_arlen), 64'(a.len));
                        check("m_arsize", 64'(m_axi_arsize), 64'(a.size));
                        check("m_arburst", 64'(m_axi_arburst), 64'(a.burst));
                        sl_q.push_back('{a.port, a.len, a.id});
                    end
                    m_hold = 1'b0;
                end
                for (int k = 0; k < S; k++) begin
                    if (vbit(s_axi_rvalid, k) && vbit(s_axi_rready, k)) begin
                        if (r_exp_q.size() == 0) begin
                            check("r_unexpected", 64'd1, 64'd0);
                        end else begin
                            b = r_exp_q.pop_front();
                            check("r_port", 64'(k), 64'(b.port));
                            check("r_data", 64'(s_axi_rdata), 64'(b.data));
                            check("r_resp", 64'(s_axi_rresp), 64'(b.resp));
                            check("r_id", 64'(s_axi_rid), 64'(b.id));
                            check("r_last", 64'(s_axi_rlast), 64'(b.last));
                        end
                    end
                end
                if (m_axi_rvalid && emr && m_axi_rlast) void'(m_oq.pop_front());
                if (eg >= 0) begin
                    m_oq.push_back(eg);
                    m_last = eg;
                    m_hold = 1'b1;
                    ar_exp_q.push_back('{req_id[eg], req_addr[eg], req_len[eg], req_size[eg],
                                         req_burst[eg], eg});
                end
                for (int k = 0; k < S; k++) ar_taken[k] = vbit(s_axi_arvalid, k) && vbit(s_axi_arready, k);
                r_taken = m_axi_rvalid && m_axi_rready;
            end
        end
    end

    task automatic first_grant_check(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #2;
            seen = (s_axi_arready != '0);
        end
        check(name, 64'(s_axi_arready), 64'd1);
    endtask

    initial begin : seq
        bit found, ok;
        do_reset();
        repeat (3) @(posedge clk);
        #2;
        check("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_m_araddr", 64'(m_axi_araddr), 64'd0);
        check("rst_s_arready", 64'(s_axi_arready), 64'd0);
        check("rst_s_rvalid", 64'(s_axi_rvalid), 64'd0);
        check("rst_m_rready", 64'(m_axi_rready), 64'd0);
        @(negedge clk); rst_n = 1'b1; bogus = 1'b1;
        repeat (6) @(negedge clk);
        bogus = 1'b0;

        // no R returned: exactly MO grants, then arready stays low
        grant_cnt = 0; count_grants = 1'b1; req_pct = 100; arready_pct = 100; slave_en = 1'b0;
        repeat (30) @(negedge clk);
        count_grants = 1'b0;
        check("backpressure_grants", 64'(grant_cnt), 64'(MO));

        req_pct = 40; arready_pct = 70; rready_pct = 75; rvalid_pct = 70; slave_en = 1'b1;
        repeat (3000) @(negedge clk);

        // clean restart, then reset mid-hold with two bursts outstanding
        slave_en = 1'b0; arready_pct = 30; req_pct = 0;
        do_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); req_pct = 100; rst_n = 1'b1;
        first_grant_check("first_grant_port0");
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk); #2;
            found = m_axi_arvalid && (m_oq.size() == 2);
        end
        check("hold_two_outstanding_reached", 64'(found), 64'd1);
        if (found) begin
            do_reset();
            #1;
            check("async_rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
            check("async_rst_m_araddr", 64'(m_axi_araddr), 64'd0);
            check("async_rst_s_arready", 64'(s_axi_arready), 64'd0);
            check("async_rst_m_rready", 64'(m_axi_rready), 64'd0);
            repeat (2) @(posedge clk);
            @(negedge clk); rst_n = 1'b1;
            first_grant_check("post_reset_grant_port0");
        end

        req_pct = 50; arready_pct = 60; rready_pct = 60; rvalid_pct = 80; slave_en = 1'b1;
        repeat (800) @(negedge clk);

        req_pct = 0; arready_pct = 100; rready_pct = 100; rvalid_pct = 100;
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk); #2;
            ok = (m_oq.size() == 0) && !m_hold && (r_exp_q.size() == 0) && (s_axi_arvalid == '0);
        end
        check("drain_complete", 64'(ok), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Single-clock AXI4 read-channel arbiter that shares one AXI master read port between S_COUNT requesters. Grants AR requests round-robin and registers the granted request onto the master port. Records grant order in an order FIFO and routes returning R beats back to the owning requester. Sits between the application read engines and the read path of the shared memory or async bridge.

## Interface
- S_COUNT, 2: number of requester ports, 2..8
- DATA_WIDTH, 64: R data width
- ADDR_WIDTH, 32: AR address width
- ID_WIDTH, 8: AR/R ID width, passed through unchanged
- MAX_OUTSTANDING, 4: maximum bursts in flight; power of 2, also the order-FIFO depth

Ports (s_* are flattened, port k occupies slice k):
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_axi_arid  in  S_COUNT*ID_WIDTH  requester AR ID
- s_axi_araddr  in  S_COUNT*ADDR_WIDTH  requester address
- s_axi_arlen  in  S_COUNT*8  burst length minus 1
- s_axi_arsize  in  S_COUNT*3  beat size
- s_axi_arburst  in  S_COUNT*2  burst type
- s_axi_arvalid  in  S_COUNT  AR valid
- s_axi_arready  out  S_COUNT  AR ready; one-hot or zero
- s_axi_rid  out  ID_WIDTH  broadcast R ID
- s_axi_rdata  out  DATA_WIDTH  broadcast R data
- s_axi_rresp  out  2  broadcast R response
- s_axi_rlast  out  1  broadcast R last
- s_axi_rvalid  out  S_COUNT  per-port R valid; one-hot or zero
- s_axi_rready  in  S_COUNT  per-port R ready
- m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst  out  ID_WIDTH/ADDR_WIDTH/8/3/2  registered granted AR
- m_axi_arvalid  out  1  AR valid, registered
- m_axi_arready  in  1  AR ready
- m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast  in  ID_WIDTH/DATA_WIDTH/2/1  R beat
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready

## Operation
- AR FSM has two states: AR_IDLE and AR_HOLD.
- AR_IDLE, grant condition: any s_axi_arvalid, outstanding < MAX_OUTSTANDING, and order FIFO not full.
- On grant:
  - Select port g round-robin, searching from the port after last_grant (wrapping) through last_grant.
  - Drive s_axi_arready[g]=1 combinationally that cycle.
  - Latch g's AR fields into the m_axi_ar* registers and set m_axi_arvalid.
  - Push g into the order FIFO, increment outstanding, set last_grant=g, go to AR_HOLD.
- AR_HOLD: all s_axi_arready=0; hold m_axi_ar* stable. On m_axi_arvalid && m_axi_arready: clear arvalid, go to AR_IDLE.
- R routing is combinational, with h = order-FIFO head:
  - s_axi_rvalid[h] = m_axi_rvalid && !order_empty; all other bits 0.
  - m_axi_rready = !order_empty && s_axi_rready[h].
  - s_axi_rid/rdata/rresp/rlast mirror the m_axi_r* inputs.
- On an R handshake with m_axi_rlast=1: pop the order FIFO and decrement outstanding.
- Grant and last-beat pop in the same cycle: outstanding unchanged; the FIFO pushes and pops both.
- The slave must return bursts in AR issue order; IDs are not used for routing.
- m_axi_rvalid with the order FIFO empty: m_axi_rready=0 and the beat stalls indefinitely. This is a protocol error and is not dropped.
- Outstanding counter width is clog2(MAX_OUTSTANDING)+1. It never exceeds MAX_OUTSTANDING and never underflows.

## Timing
- Reset (rst_n=0, async) sets:
  - m_axi_arvalid=0 and all m_axi_ar* registers to 0.
  - AR FSM=AR_IDLE, outstanding=0, order FIFO empty, last_grant=S_COUNT-1, so port 0 has first priority.
  - Combinational outputs: s_axi_arready=0, s_axi_rvalid=0, m_axi_rready=0.
- Reset deassertion is synchronized externally; the block takes no action on the first edge.
- AR latency: s_axi_arready pulse in cycle N; m_axi_arvalid high from cycle N+1.
- With m_axi_arready held high, AR throughput is one grant per 2 cycles.
- R path has zero latency and no R storage in the block.
- Reset mid-burst: the FIFO, counter and FSM clear immediately; beats still in flight must be flushed by the system-level reset.

## Test plan
- Single request: port 0 arvalid, arlen=3, m_axi_arready=1 → s_axi_arready[0] in cycle 0, m_axi_arvalid in cycle 1 only; 4 R beats appear on s_axi_rvalid[0] only; outstanding returns to 0 after rlast.
- Round-robin: ports 0 and 1 both hold arvalid for 4 grants → grant order 0,1,0,1; m_axi_araddr matches each grant.
- Back-pressure: MAX_OUTSTANDING=4 and no R beats returned → exactly 4 grants, then s_axi_arready stays 0. One rlast handshake allows exactly one more grant.
- Simultaneous grant and pop: issue a grant in the same cycle as an rlast handshake → outstanding unchanged and FIFO order preserved; the next burst routes to the correct port.
- R stall: s_axi_rready[h]=0 while m_axi_rvalid=1 → m_axi_rready=0 and no pop. After s_axi_rready rises, the beat completes the cycle it rises.
- Async reset: assert rst_n=0 mid-cycle during AR_HOLD with 2 outstanding → m_axi_arvalid=0 immediately, outstanding=0, and port 0 wins the first grant after release.
